pipelined_rca: RTL
==================

// Module: pipelined_rca
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor. It is the next
//  generation of the team's fixed 4-bit RCA.
//  - Splits WIDTH-bit operands into SLICE-bit slices; one slice is added per
//    pipeline stage, and the carry is registered between stages.
//  - Valid/ready handshake on both sides with full backpressure.
//  - Sits between operand-issue logic and any consumer of sum/carry/overflow.
// PARAMETERS
//  WIDTH  32  operand and sum width in bits; must be a multiple of SLICE
//  SLICE   8  bits added per stage; STAGES = WIDTH/SLICE (1..16)
// PORTS
//  clk        in   1      single clock; every register updates on posedge clk
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      in1/in2/cin/sub carry a valid operation
//  in_ready   out  1      adder accepts the operation this cycle
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: A+B+cin; 1: A-B (B inverted, carry-in forced to 1)
//  out_valid  out  1      sum/cout/ovf hold a valid result
//  out_ready  in   1      consumer takes the result this cycle
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (for subtraction: 1 = no borrow)
//  ovf        out  1      signed overflow = carry-into-MSB XOR cout
// BEHAVIOUR
//  - Reset: all stage valid bits are cleared, so out_valid=0. sum, cout and ovf
//    are 0. in_ready=1 as soon as rst_n is high.
//  - Reset mid-operation discards every in-flight operation. No result appears
//    for operations accepted before reset.
//  - Advance condition: adv = ~out_valid | out_ready. in_ready = adv
//    (combinational). An operation is accepted when in_valid & in_ready.
//  - When adv=1, every stage shifts forward by one. When adv=0, all stage
//    registers hold their values (global stall, no bubbles collapse).
//  - Stage 0 computes slice 0 as A[SLICE-1:0] + B'[SLICE-1:0] + c0, where
//    B' = sub ? ~in2 : in2 and c0 = sub ? 1 : cin. Stage 0 registers:
//    the partial sum, the slice carry, and the still-unused upper slices of
//    A and B'.
//  - Stage k (1..STAGES-1) adds slice k using the registered carry from stage
//    k-1 and appends its slice to the partial sum.
//  - Latency: STAGES cycles from the accepting edge to out_valid, when there
//    is no stall.
//  - Throughput: one operation per cycle while out_ready=1.
//  - out_valid/sum/cout/ovf stay stable while out_valid & ~out_ready.
//  - Simultaneous accept and drain in the same cycle is legal, and no bubble
//    is inserted.
//  - Bubbles: in_valid=0 while adv=1 shifts in an invalid stage. Stage data
//    may change, but it is never visible while its valid bit is 0.
//  - ovf is taken from the MSB slice: carry into bit WIDTH-1, XOR cout.
//  - Wrap-around: the sum is truncated to WIDTH bits, and the carry is
//    reported only on cout.
//  - STAGES=1 degenerates to a single-register adder with latency 1.
//  - Illegal parameters (WIDTH % SLICE != 0, or SLICE > WIDTH) must stop
//    elaboration via a generate-time error.
// STRUCTURE
//  - Shared package: localparam STAGES, and the sub-mode encoding constant
//    MODE_ADD=0 / MODE_SUB=1.
//  - One sub-module, rca_slice: a parametrised SLICE-bit combinational ripple
//    adder built from full_adder instances. Ports: a, b, ci, s, co, c_msb_in.
//  - The top level generates STAGES rca_slice instances, plus per-stage
//    registers: valid, carry, partial sum, and the remaining operand slices.
// TESTING (WIDTH=32, SLICE=8, STAGES=4)
//  1. Reset, then hold in_valid=0 -> out_valid=0, sum=0, in_ready=1.
//  2. A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0, out_ready=1 ->
//     four cycles later: sum=0, cout=1, ovf=0 (carry ripples through all
//     stages).
//  3. A=0x7FFFFFFF, B=1, sub=0 -> sum=0x80000000, cout=0, ovf=1.
//     A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
//  4. Back-to-back 8 operations with out_ready=1 -> 8 results on 8
//     consecutive cycles, in order, all matching the model.
//  5. Hold out_ready=0 for 6 cycles with the pipe full -> in_ready=0, and the
//     output stays stable. Release -> no loss or duplication.
//  6. Assert rst_n=0 with 3 operations in flight -> out_valid=0 at once.
//     After release, none of those 3 results ever appears.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_rca_pkg
//  Description : Shared constants for the pipelined ripple-carry adder:
//                default geometry, derived stage count and the sub-mode
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipelined_rca_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;
    localparam int STAGES    = DEF_WIDTH / DEF_SLICE;

    // Operation select encoding on the sub input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Stage count, clamped to at least one so that array declarations stay
    // legal long enough for the parameter check to report a bad geometry.
    function automatic int calc_stages(input int width, input int slice);
        int n;
        n = (slice > 0) ? (width / slice) : 1;
        return (n < 1) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_rca_slice.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder / rca_slice
//  Description : One-bit full adder and a W-bit combinational ripple adder
//                built from it. c_msb_in exposes the carry entering the top
//                bit so the caller can form signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module rca_slice
    import pipelined_rca_pkg::*;
#(
    parameter int W = DEF_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb_in
);
    // w_c[i] is the carry entering bit i
    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .i_a  (a[i]),
            .i_b  (b[i]),
            .i_ci (w_c[i]),
            .o_s  (s[i]),
            .o_co (w_c[i+1])
        );
    end

    assign co       = w_c[W];
    assign c_msb_in = w_c[W-1];
endmodule
`default_nettype wire

// File: rtl/pipelined_rca.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_rca
//  Description : Parametrised pipelined ripple-carry adder/subtractor. One
//                SLICE-bit slice is added per stage with the carry registered
//                between stages. Valid/ready on both sides, global stall on
//                backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N_STG = calc_stages(WIDTH, SLICE);

    // Reject geometries that cannot be split into whole slices
    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0) || (N_STG > 16)) begin : g_bad_params
        $error("pipelined_rca: WIDTH must be a multiple of SLICE, SLICE <= WIDTH, and WIDTH/SLICE <= 16");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Per-stage pipeline registers
    logic             r_valid [N_STG];
    logic             r_carry [N_STG];
    logic [WIDTH-1:0] r_psum  [N_STG];
    logic [WIDTH-1:0] r_a     [N_STG];
    logic [WIDTH-1:0] r_b     [N_STG];
    logic             r_ovf;

    // Per-stage slice adder connections
    logic [SLICE-1:0] w_sa [N_STG];
    logic [SLICE-1:0] w_sb [N_STG];
    logic [SLICE-1:0] w_s  [N_STG];
    logic             w_ci [N_STG];
    logic             w_co [N_STG];
    logic             w_cm [N_STG];

    // The whole pipe moves together whenever the output slot is free or drained
    assign w_adv    = ~r_valid[N_STG-1] | out_ready;
    assign in_ready = w_adv;

    // Subtraction is A + ~B + 1; cin is ignored in that mode
    assign w_b_eff = (sub == MODE_SUB) ? ~in2 : in2;
    assign w_c0    = (sub == MODE_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < N_STG; k++) begin : g_stage
        rca_slice #(
            .W (SLICE)
        ) u_slice (
            .a        (w_sa[k]),
            .b        (w_sb[k]),
            .ci       (w_ci[k]),
            .s        (w_s[k]),
            .co       (w_co[k]),
            .c_msb_in (w_cm[k])
        );

        if (k == 0) begin : g_first
            assign w_sa[k] = in1[SLICE-1:0];
            assign w_sb[k] = w_b_eff[SLICE-1:0];
            assign w_ci[k] = w_c0;

            // Stage 0: capture slice 0 result and the operands still to be added
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_carry[k] <= 1'b0;
                    r_psum[k]  <= '0;
                    r_a[k]     <= '0;
                    r_b[k]     <= '0;
                end else if (w_adv) begin
                    r_valid[k] <= in_valid;
                    r_carry[k] <= w_co[k];
                    r_psum[k]  <= WIDTH'(w_s[k]);
                    r_a[k]     <= in1;
                    r_b[k]     <= w_b_eff;
                end
            end
        end else begin : g_next
            assign w_sa[k] = r_a[k-1][k*SLICE +: SLICE];
            assign w_sb[k] = r_b[k-1][k*SLICE +: SLICE];
            assign w_ci[k] = r_carry[k-1];

            // Stage k: add slice k with the carry from stage k-1 and append it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_carry[k] <= 1'b0;
                    r_psum[k]  <= '0;
                    r_a[k]     <= '0;
                    r_b[k]     <= '0;
                end else if (w_adv) begin
                    r_valid[k] <= r_valid[k-1];
                    r_carry[k] <= w_co[k];
                    // Bits above slice k-1 are still zero in the partial sum
                    r_psum[k]  <= r_psum[k-1] | (WIDTH'(w_s[k]) << (k * SLICE));
                    r_a[k]     <= r_a[k-1];
                    r_b[k]     <= r_b[k-1];
                end
            end
        end
    end

    // Signed overflow comes from the MSB slice as it enters the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_cm[N_STG-1] ^ w_co[N_STG-1];
        end
    end

    assign out_valid = r_valid[N_STG-1];
    assign sum       = r_psum[N_STG-1];
    assign cout      = r_carry[N_STG-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
